// File: rtl/adder_pkg.sv
// Shared constants and stage-count helper for the pipelined carry-lookahead adder.
package adder_pkg;

  localparam int unsigned GroupWidth = 4;

  // One pipeline stage per GPS lookahead groups; latency equals the stage count.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned gps);
    return width / (GroupWidth * gps);
  endfunction

endpackage

// File: rtl/cla_group_4.sv
// Combinational 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla_group_4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       G,
  output logic       P,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = A & B;
  assign p = A | B;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;
  assign cout = G | (P & cin);

  assign sum = A ^ B ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: each stage resolves GPS lookahead groups, with operand skew
// and sum deskew registers so a whole result leaves the last stage at once.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GPS   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int unsigned SW = GroupWidth * GPS;
  localparam int unsigned NS = num_stages(WIDTH, GPS);

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  // Single global enable: the pipeline only stalls when a finished result is blocked.
  assign o_ready = ~(o_valid & ~i_ready);
  assign en      = o_ready;
  assign b_eff   = i_add2 ^ {WIDTH{i_sub}};
  assign cin0    = i_sub | i_carry;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int unsigned UpW  = WIDTH - k * SW;
    localparam int unsigned SumW = (k + 1) * SW;

    logic [UpW-1:0]  a_up;
    logic [UpW-1:0]  b_up;
    logic            c_in;
    logic            v_in;
    logic [SumW-1:0] s_all;
    logic [SW-1:0]   a_s;
    logic [SW-1:0]   b_s;
    logic [SW-1:0]   s_s;
    logic [GPS-1:0]  grp_g;
    logic [GPS-1:0]  grp_p;
    logic [GPS-1:0]  grp_co;
    logic [GPS:0]    c_g;
    logic            unused_co;
    logic            v_q;
    logic            c_q;
    logic [SumW-1:0] s_q;

    if (k == 0) begin : g_first
      assign a_up  = i_add1;
      assign b_up  = b_eff;
      assign c_in  = cin0;
      assign v_in  = i_valid;
      assign s_all = s_s;
    end else begin : g_next
      assign a_up  = g_stage[k-1].g_skew.a_q;
      assign b_up  = g_stage[k-1].g_skew.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_all = {s_s, g_stage[k-1].s_q};
    end

    assign a_s = a_up[SW-1:0];
    assign b_s = b_up[SW-1:0];

    for (genvar g = 0; g < GPS; g++) begin : g_grp
      cla_group_4 u_grp (
        .A    (a_s[4*g +: 4]),
        .B    (b_s[4*g +: 4]),
        .cin  (c_g[g]),
        .sum  (s_s[4*g +: 4]),
        .G    (grp_g[g]),
        .P    (grp_p[g]),
        .cout (grp_co[g])
      );
    end

    // Group carries come from the group G/P terms, never from a neighbour's cout.
    always_comb begin
      logic acc;
      logic pp;
      c_g    = '0;
      c_g[0] = c_in;
      for (int g = 1; g <= int'(GPS); g++) begin
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = g - 1; j >= 0; j--) begin
          acc = acc | (grp_g[j] & pp);
          pp  = pp & grp_p[j];
        end
        c_g[g] = acc | (pp & c_in);
      end
    end

    assign unused_co = ^grp_co;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= c_g[GPS];
        s_q <= s_all;
      end
    end

    if (k < NS - 1) begin : g_skew
      logic [UpW-SW-1:0] a_q;
      logic [UpW-SW-1:0] b_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_up[UpW-1:SW];
          b_q <= b_up[UpW-1:SW];
        end
      end
    end

    if (k == NS - 1) begin : g_last
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_g[GPS] ^ (s_s[SW-1] ^ a_s[SW-1] ^ b_s[SW-1]);
        end
      end
    end
  end

  assign o_valid    = g_stage[NS-1].v_q;
  assign o_sum      = g_stage[NS-1].s_q;
  assign o_carry    = g_stage[NS-1].c_q;
  assign o_overflow = g_stage[NS-1].g_last.ovf_q;
  assign o_zero     = o_valid & (o_sum == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 16-bit/GPS=1 and a 32-bit/GPS=2 instance run in lockstep.
module tb_pipelined_cla_adder;
  import adder_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic [31:0] a32;
    logic [31:0] b32;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        sub;
  logic        cin;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [31:0] a32;
  logic [31:0] b32;

  logic        rdy16, ov16, c16, v16, z16;
  logic [15:0] s16;
  logic        rdy32, ov32, c32, v32, z32;
  logic [31:0] s32;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_in16 = 0;
  int   n_out16 = 0;
  res_t q16[$];
  res_t q32[$];
  res_t cur16;
  res_t cur32;
  vec_t vecs[9];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GPS(1)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy16),
    .i_add1(a16), .i_add2(b16), .i_carry(cin), .i_sub(sub),
    .o_valid(ov16), .i_ready(ready), .o_sum(s16), .o_carry(c16),
    .o_overflow(v16), .o_zero(z16)
  );

  pipelined_cla_adder #(.WIDTH(32), .GPS(2)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy32),
    .i_add1(a32), .i_add2(b32), .i_carry(cin), .i_sub(sub),
    .o_valid(ov32), .i_ready(ready), .o_sum(s32), .o_carry(c32),
    .o_overflow(v32), .o_zero(z32)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input logic ci);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [32:0] full;
    res_t r;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    bb     = (s ? ~b : b) & mask;
    full   = {1'b0, a & mask} + {1'b0, bb} + {32'h0, (s ? 1'b1 : ci)};
    r.sum  = full[31:0] & mask;
    r.c    = full[w];
    r.v    = (a[w-1] == bb[w-1]) && (r.sum[w-1] != a[w-1]);
    r.z    = (r.sum == 32'h0);
    return r;
  endfunction

  task automatic set_op(input logic s, input logic ci, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] x2, input logic [31:0] y2, input res_t e16);
    sub   = s;
    cin   = ci;
    a16   = x;
    b16   = y;
    a32   = x2;
    b32   = y2;
    cur16 = e16;
    cur32 = model(32, x2, y2, s, ci);
  endtask

  task automatic apply(input vec_t t);
    res_t e;
    e.sum = {16'h0, t.sum};
    e.c   = t.c;
    e.v   = t.v;
    e.z   = t.z;
    set_op(t.sub, t.cin, t.a, t.b, t.a32, t.b32, e);
  endtask

  task automatic rand_op();
    logic        s, ci;
    logic [15:0] x, y;
    logic [31:0] x2, y2;
    s  = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    x  = 16'($urandom);
    y  = 16'($urandom);
    x2 = $urandom;
    y2 = $urandom;
    set_op(s, ci, x, y, x2, y2, model(16, {16'h0, x}, {16'h0, y}, s, ci));
  endtask

  // Scoreboard: compare before push so a spurious result cannot match a fresh entry.
  always @(negedge clk) begin
    if (rst) begin
      n_in16 -= q16.size();
      q16.delete();
      q32.delete();
    end else begin
      if (ov16) begin
        if (q16.size() == 0) chk("spurious16", 64'(ov16), 64'd0);
        else begin
          chk("res16", {s16, c16, v16, z16}, {q16[0].sum[15:0], q16[0].c, q16[0].v, q16[0].z});
          if (ready) begin
            void'(q16.pop_front());
            n_out16++;
          end
        end
      end
      if (ov32) begin
        if (q32.size() == 0) chk("spurious32", 64'(ov32), 64'd0);
        else begin
          chk("res32", {s32, c32, v32, z32}, {q32[0].sum, q32[0].c, q32[0].v, q32[0].z});
          if (ready) void'(q32.pop_front());
        end
      end
      if (valid && rdy16) begin
        q16.push_back(cur16);
        n_in16++;
      end
      if (valid && rdy32) q32.push_back(cur32);
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q16.size() == 0 && q32.size() == 0) break;
      @(negedge clk);
    end
    chk("drain16", 64'(q16.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic stream(input int n, input bit rnd);
    int   idx;
    int   cyc;
    logic acc;
    idx = 0;
    cyc = 0;
    @(posedge clk); #1;
    rand_op();
    valid = 1'b1;
    while (idx < n && cyc < 400) begin
      if (rnd) begin
        ready = ($urandom_range(0, 3) != 0);
        valid = ($urandom_range(0, 3) != 0);
      end else begin
        ready = !(cyc >= 10 && cyc < 13);
      end
      @(negedge clk);
      if (!rnd && !ready) begin
        chk("stall_ready16", 64'(rdy16), 64'd0);
        chk("stall_ready32", 64'(rdy32), 64'd0);
      end
      acc = valid & rdy16;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) rand_op();
      end
    end
    valid = 1'b0;
    ready = 1'b1;
    chk("stream_accepted", 64'(idx), 64'(n));
  endtask

  initial begin
    int lat16, lat32, seen;
    vecs[0] = '{1'b0, 1'b1, 16'h1234, 16'h0FCD, 16'h2202, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0FCD_A987};
    vecs[1] = '{1'b1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h5, 32'h5};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1};
    vecs[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1};
    vecs[5] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h1};
    vecs[6] = '{1'b1, 1'b1, 16'h0003, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 32'h3, 32'h1};
    vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[8] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000};

    // Operands presented during reset must be ignored.
    rst   = 1'b1;
    valid = 1'b1;
    ready = 1'b1;
    apply(vecs[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out16", {ov16, s16, c16, v16, z16}, 64'd0);
    chk("rst_out32", {ov32, s32, c32, v32, z32}, 64'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("ready16_after_rst", 64'(rdy16), 64'd1);
    chk("ready32_after_rst", 64'(rdy32), 64'd1);
    chk("valid_after_rst", 64'(ov16 | ov32), 64'd0);

    // Single-op latency, counted from the accepting cycle.
    @(posedge clk); #1;
    apply(vecs[0]);
    valid = 1'b1;
    lat16 = 0;
    lat32 = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      if (ov16 && lat16 == 0) lat16 = cyc;
      if (ov32 && lat32 == 0) lat32 = cyc;
    end
    chk("latency16", 64'(lat16), 64'(num_stages(16, 1)));
    chk("latency32", 64'(lat32), 64'(num_stages(32, 2)));

    // Directed vector table, back to back.
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      valid = 1'b1;
    end
    @(posedge clk); #1;
    valid = 1'b0;
    drain();

    stream(20, 1'b0);
    drain();
    stream(30, 1'b1);
    drain();

    // Mid-flight reset discards three accepted operations.
    @(posedge clk); #1;
    rand_op();
    valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      rand_op();
    end
    @(posedge clk); #1;
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out16", {ov16, s16, c16, v16, z16}, 64'd0);
    chk("midrst_out32", {ov32, s32, c32, v32, z32}, 64'd0);
    chk("midrst_ready16", 64'(rdy16), 64'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov16 || ov32) seen++;
    end
    chk("midrst_no_stale", 64'(seen), 64'd0);
    chk("inout_count16", 64'(n_out16), 64'(n_in16));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter GPS, 1, 4-bit lookahead groups per pipeline stage; SHALL divide WIDTH/4.
REQ-003 Ports SHALL be exactly:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_valid  in  1  input operands valid.
o_ready  out  1  block can accept operands this cycle.
i_add1  in  WIDTH  operand A.
i_add2  in  WIDTH  operand B.
i_carry  in  1  carry-in; ignored when i_sub=1.
i_sub  in  1  1 = A - B; 0 = A + B + i_carry.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts result.
o_sum  out  WIDTH  result bits.
o_carry  out  1  carry-out of MSB; for subtraction, 1 = no borrow.
o_overflow  out  1  signed two's-complement overflow.
o_zero  out  1  o_sum == 0.

Function
REQ-004 Number of stages NS = WIDTH/(4*GPS); latency from accepted input to o_valid SHALL be exactly NS cycles with no stall.
REQ-005 Subtract mode SHALL use B' = ~i_add2 and a group-0 carry-in of 1; add mode SHALL use B' = i_add2 and carry-in = i_carry.
REQ-006 Each 4-bit group SHALL compute Gi = Ai&B'i and Pi = Ai|B'i, with carry lookahead inside the group and group-level G/P across the GPS groups of one stage; no ripple through full-adder carry outputs.
REQ-007 Stage k SHALL take the stage carry registered by stage k-1. Operand bits above stage k SHALL be delayed by k registers. Sum bits below stage k SHALL be delayed so all bits of one result leave together.
REQ-008 o_carry SHALL equal the carry out of bit WIDTH-1. o_overflow SHALL equal (carry into MSB) XOR (carry out of MSB). o_zero SHALL be computed from the final aligned o_sum.
REQ-009 Each stage SHALL carry a valid bit. A transfer in SHALL occur when i_valid & o_ready. A transfer out SHALL occur when o_valid & i_ready.
REQ-010 o_ready SHALL be !(o_valid & !i_ready). When o_ready=0 the whole pipeline SHALL hold (global enable), and no data or valid bit SHALL change.
REQ-011 Bubbles SHALL propagate: a stage whose valid is 0 SHALL NOT block earlier stages while the enable is high.
REQ-012 Results SHALL emerge in acceptance order with no loss or duplication under any i_valid/i_ready pattern.
REQ-013 While o_valid=1 and i_ready=0, o_sum, o_carry, o_overflow and o_zero SHALL stay stable.
REQ-014 Simultaneous input accept and output drain in one cycle SHALL both occur. Full throughput is one result per cycle.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH on o_sum. Wrap-around SHALL be reported only through o_carry and o_overflow.

Reset
REQ-016 With i_rst=1 at a clock edge, all stage valid bits, o_valid, o_sum, o_carry, o_overflow and o_zero SHALL be 0 after that edge.
REQ-017 Reset mid-operation SHALL discard all in-flight results; none SHALL appear after reset deasserts.
REQ-018 o_ready SHALL be 1 in the first cycle after reset.
REQ-019 Inputs presented while i_rst=1 SHALL be ignored.

Structure
REQ-020 The group width constant (4) and the stage-count/latency function SHALL live in the shared package adder_pkg, used by this block and its bench.
REQ-021 The 4-bit lookahead slice SHALL be a separate sub-module, cla_group_4, with ports A[3:0], B[3:0], cin, sum[3:0], group G, group P and cout. It SHALL be purely combinational.
REQ-022 Registers SHALL exist only at stage boundaries and in the skew/deskew chains.

Verification (WIDTH=16, GPS=1, NS=4)
REQ-023 Add 0x1234 + 0x0FCD, i_carry=1, i_ready=1 -> 4 cycles later o_sum=0x2202, carry=0, overflow=0, zero=0.
REQ-024 Sub 0x0005 - 0x0005 -> o_sum=0x0000, zero=1, carry=1. Sub 0x0000 - 0x0001 -> 0xFFFF, carry=0.
REQ-025 Add 0x7FFF + 0x0001 -> 0x8000, overflow=1. Add 0xFFFF + 0x0001 -> 0x0000, carry=1, zero=1.
REQ-026 Back-to-back 20 random operations, with i_ready low for 3 cycles mid-stream -> o_ready low during the stall, outputs held, all 20 results in order and matching the reference model.
REQ-027 Accept 3 operations, assert i_rst for one cycle -> o_valid=0 thereafter, no stale result, o_ready=1 the next cycle.
REQ-028 Repeat REQ-023 to REQ-026 with WIDTH=32 and GPS=2 -> latency 4, identical correctness.
